// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data-memory responder:
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - access-legality helpers used by the top level
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // RV32I width codes
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Stores only know B/H/W; loads additionally allow the unsigned variants.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write) begin
      return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane logic for a 32-bit little-endian data memory.
// Ports:
//   funct3      in   RV32I width code of the access
//   addr_lo     in   byte offset within the word (addr[1:0])
//   wdata       in   right-aligned store data
//   rdata_word  in   full memory word at the addressed index
//   byte_en     out  per-lane write enables for a store
//   wdata_lanes out  store data replicated onto every lane it may land in
//   load_data   out  selected and sign/zero-extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic signed [7:0]  sel_byte;
  logic signed [15:0] sel_half;

  always_comb begin
    sel_byte    = rdata_word[{addr_lo, 3'b000} +: 8];
    sel_half    = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    load_data   = 32'h0000_0000;

    // Replicating the store data means the enable mask alone picks the lanes.
    case (funct3[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    case (funct3)
      F3_B:    load_data = 32'(sel_byte);
      F3_BU:   load_data = {24'h00_0000, $unsigned(sel_byte)};
      F3_H:    load_data = 32'(sel_half);
      F3_HU:   load_data = {16'h0000, $unsigned(sel_half)};
      F3_W:    load_data = rdata_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Valid/ready data-memory slave with a fixed, parameterised response latency.
// One request is in flight at a time: IDLE accepts, WAIT counts down LATENCY
// cycles, RESP presents the result until the initiator takes it.
// Parameters:
//   DEPTH_WORDS  number of 32-bit storage words
//   LATENCY      wait cycles between accept and response (0..15)
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_write, req_addr, req_wdata, req_funct3
//   rsp_valid/rsp_ready, rsp_rdata, rsp_error
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        acc_idle;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_funct3;
  logic        acc_write;
  logic [31:0] word_idx;
  logic        acc_oor;
  logic        acc_err;
  logic [31:0] mem_word;
  logic        do_access;
  logic        mem_we;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;
  logic [31:0] load_data;

  // With LATENCY=0 the access happens on the accept edge itself, before the
  // holding registers are loaded, so in IDLE the request inputs feed the access.
  always_comb begin
    acc_idle   = (state_q == ST_IDLE);
    acc_addr   = acc_idle ? req_addr   : addr_q;
    acc_wdata  = acc_idle ? req_wdata  : wdata_q;
    acc_funct3 = acc_idle ? req_funct3 : funct3_q;
    acc_write  = acc_idle ? req_write  : write_q;
    word_idx   = {2'b00, acc_addr[31:2]};
    acc_oor    = word_idx >= 32'(DEPTH_WORDS);
    acc_err    = f3_illegal(acc_write, acc_funct3) | misaligned(acc_funct3, acc_addr[1:0]) | acc_oor;
    mem_word   = acc_oor ? 32'h0000_0000 : mem_q[word_idx[IDX_W-1:0]];
  end

  mem_lane_align u_lane_align (
    .funct3      (acc_funct3),
    .addr_lo     (acc_addr[1:0]),
    .wdata       (acc_wdata),
    .rdata_word  (mem_word),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    write_d     = write_q;
    do_access   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          write_d  = req_write;
          if (LATENCY == 0) begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // <= rather than == keeps the counter from ever wrapping below zero.
        if (cnt_q <= 4'd1) begin
          state_d   = ST_RESP;
          cnt_d     = 4'd0;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Returning to IDLE (not accepting) on the handshake edge gives the
        // mandatory one-cycle gap before the next request.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_rdata_d = 32'h0000_0000;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_access) begin
      rsp_error_d = acc_err;
      rsp_rdata_d = (acc_err || acc_write) ? 32'h0000_0000 : load_data;
    end
  end

  // Gating with reset discards a commit that would coincide with an abort.
  assign mem_we = do_access && acc_write && !acc_err && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Request holding registers: only meaningful while a transaction is open.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    funct3_q <= funct3_d;
    write_q  <= write_d;
  end

  // Storage array: synchronous byte-lane write, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx[IDX_W-1:0]][8*b +: 8] <= wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench: a vector table of single transactions on a LATENCY=2
// instance, followed by hand-written sequences for back-pressure, reset abort
// and a LATENCY=0 instance.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [2:0]  req_funct3_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_error_z;
  logic [31:0] rsp_rdata_z;

  int n_vec  = 0;
  int n_miss = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_funct3(req_funct3_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_error(rsp_error_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [0:26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request in IDLE; returns #1 after the accept edge.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  // From just after the accept edge: check the response and that req_ready
  // stays low for exactly LATENCY+1 = 3 cycles.
  task automatic finish_access(input string name, input logic [31:0] exp_rdata, input logic exp_err);
    int low;
    bit seen;
    bit done;
    low  = 0;
    seen = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready) begin
        done = 1;
      end else begin
        if (rsp_valid && !seen) begin
          seen = 1;
          chk({name, "_rdata"}, rsp_rdata, exp_rdata);
          chk({name, "_err"}, 32'(rsp_error), 32'(exp_err));
        end
        low++;
        @(posedge clk); #1;
      end
    end
    chk({name, "_rsp_seen"}, 32'(seen), 32'd1);
    chk({name, "_busy_cycles"}, 32'(low), 32'd3);
  endtask

  task automatic z_access(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
    req_valid_z  = 1'b1;
    req_write_z  = wr;
    req_funct3_z = f3;
    req_addr_z   = addr;
    req_wdata_z  = wdata;
    @(posedge clk); #1;
    req_valid_z  = 1'b0;
    chk({name, "_valid"}, 32'(rsp_valid_z), 32'd1);
    chk({name, "_rdata"}, rsp_rdata_z, exp_rdata);
    chk({name, "_err"}, 32'(rsp_error_z), 32'(exp_err));
    chk({name, "_busy"}, 32'(req_ready_z), 32'd0);
    @(posedge clk); #1;
    chk({name, "_ready_back"}, 32'(req_ready_z), 32'd1);
  endtask

  initial begin
    int k;
    //          wr    f3    addr          wdata         exp_rdata     err
    tbl[0]  = '{1'b1, F_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, F_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, F_W,  32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b1, F_B,  32'h0000_0021, 32'h0000_0080, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, F_B,  32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b0};
    tbl[5]  = '{1'b0, F_BU, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b0};
    tbl[6]  = '{1'b0, F_W,  32'h0000_0020, 32'h0,         32'h1122_8044, 1'b0};
    tbl[7]  = '{1'b0, F_H,  32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
    tbl[8]  = '{1'b1, F_W,  32'h0000_0022, 32'h5555_5555, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b0, F_W,  32'h0000_0020, 32'h0,         32'h1122_8044, 1'b0};
    tbl[10] = '{1'b1, F_H,  32'h0000_0012, 32'h0000_BEEF, 32'h0000_0000, 1'b0};
    tbl[11] = '{1'b0, F_HU, 32'h0000_0012, 32'h0,         32'h0000_BEEF, 1'b0};
    tbl[12] = '{1'b0, F_H,  32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0};
    tbl[13] = '{1'b0, F_W,  32'h0000_0010, 32'h0,         32'hBEEF_BEEF, 1'b0};
    tbl[14] = '{1'b0, F_B,  32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0};
    tbl[15] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,       32'h0000_0000, 1'b1};
    tbl[16] = '{1'b1, 3'b100, 32'h0000_0010, 32'h0,       32'h0000_0000, 1'b1};
    tbl[17] = '{1'b0, F_W,  32'h0000_0010, 32'h0,         32'hBEEF_BEEF, 1'b0};
    tbl[18] = '{1'b1, F_B,  32'h0000_0023, 32'h0000_007F, 32'h0000_0000, 1'b0};
    tbl[19] = '{1'b0, F_B,  32'h0000_0023, 32'h0,         32'h0000_007F, 1'b0};
    tbl[20] = '{1'b0, F_W,  32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
    tbl[21] = '{1'b1, F_W,  32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    tbl[22] = '{1'b0, F_W,  32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    tbl[23] = '{1'b1, F_W,  32'h0000_0040, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    tbl[24] = '{1'b0, F_HU, 32'h0000_0022, 32'h0,         32'h0000_7F22, 1'b0};
    tbl[25] = '{1'b1, F_H,  32'h0000_0021, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
    tbl[26] = '{1'b0, F_W,  32'h0000_0020, 32'h0,         32'h7F22_8044, 1'b0};

    reset        = 1'b1;
    req_valid    = 1'b0; req_write   = 1'b0; req_addr   = '0; req_wdata   = '0; req_funct3   = F_W;
    rsp_ready    = 1'b1;
    req_valid_z  = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_funct3_z = F_W;
    rsp_ready_z  = 1'b1;

    // Reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_z_req_ready", 32'(req_ready_z), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven single transactions
    for (int i = 0; i < 27; i++) begin
      do_req(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
      finish_access($sformatf("vec%0d", i), tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Back-pressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    do_req(1'b0, F_W, 32'h0000_0010, 32'h0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_reach_resp", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_valid%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold_rdata%0d", c), rsp_rdata, 32'hBEEF_BEEF);
      chk($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    // A request already waiting must not be taken on the handshake edge
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = F_W;
    req_addr   = 32'h0000_0020;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    chk("hs_rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("hs_req_ready_rise", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hs_next_accepted", 32'(req_ready), 32'd0);
    finish_access("hs_next", 32'h7F22_8044, 1'b0);

    // Reset during WAIT aborts a store
    do_req(1'b1, F_W, 32'h0000_0040, 32'h1234_5678);
    chk("abort_in_wait", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'h0);
    chk("abort_rsp_error", 32'(rsp_error), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, F_W, 32'h0000_0040, 32'h0);
    finish_access("abort_old", 32'h0BAD_F00D, 1'b0);

    // Zero-latency instance
    z_access("z_oor", 1'b0, F_W, 32'h0000_1000, 32'h0, 32'h0, 1'b1);
    z_access("z_sw", 1'b1, F_W, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 1'b0);
    z_access("z_lw", 1'b0, F_W, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0);
    z_access("z_lb", 1'b0, F_B, 32'h0000_000B, 32'h0, 32'hFFFF_FFCA, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
